// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared types and constants for the rv32i MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    localparam logic [3:0] MBE_ALL = 4'b1111;

    // funct3[1:0] encodes access size for both loads and stores: 01 half, 10 word.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Brief    : Data-cache request/response bus between MEM stage and D-cache.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output address, read, write, mbe, wdata,
        input  resp, rdata
    );

    modport slave (
        input  address, read, write, mbe, wdata,
        output resp, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_store_align.sv
`default_nettype none
// ============================================================================
// Module   : store_align
// Brief    : Byte-enable and lane-replicated write data for sb/sh/sw.
// Revision : 1.0 - initial release
// ============================================================================
module store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_mbe,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_mbe   = 4'b0000;
        o_wdata = 32'h0;
        case (i_funct3)
            sb: begin
                o_mbe   = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
            end
            sh: begin
                o_mbe   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rs2[15:0]}};
            end
            sw: begin
                o_mbe   = MBE_ALL;
                o_wdata = i_rs2;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : rv32i data-memory initiator; holds the D-cache request and stalls
//            the pipeline until the response arrives.
//            Optional macro MEM_MISALIGN_TRAP_EN adds the misaligned output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  rv32i_control_word      ctrl_in,
    input  logic                   valid_in,
    input  logic [31:0]            alu_out,
    input  logic [31:0]            rs2_out,
    input  logic                   advance,
    mem_stage_if.master            dmem,
    output logic [31:0]            mem_rdata_out,
    output logic                   stall_req,
    output logic [STALL_CNT_W-1:0] stall_count
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                   misaligned
`endif
);

    localparam logic [STALL_CNT_W-1:0] c_cnt_one = 1;

    mem_state_t             r_state;
    logic [31:0]            r_rdata_q;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_go;
    logic        w_req_en;
    logic [3:0]  w_st_mbe;
    logic [31:0] w_st_wdata;
    logic        w_unused_opcode;

    assign w_unused_opcode = ^ctrl_in.opcode;

    assign w_mem_op = valid_in & (ctrl_in.mem_read | ctrl_in.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_mem_op & access_misaligned(ctrl_in.funct3, alu_out[1:0]);
    assign misaligned   = w_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    // A misaligned access is dropped entirely: no request, no stall.
    assign w_go     = w_mem_op & ~w_misaligned;
    assign w_req_en = ~rst & w_go & (r_state != DONE);

    assign dmem.address = {alu_out[31:2], 2'b00};
    assign dmem.read    = w_req_en & ctrl_in.mem_read;
    assign dmem.write   = w_req_en & ctrl_in.mem_write;
    assign stall_req    = w_req_en & ~dmem.resp;

    store_align u_store_align (
        .i_funct3  (ctrl_in.funct3),
        .i_addr_lo (alu_out[1:0]),
        .i_rs2     (rs2_out),
        .o_mbe     (w_st_mbe),
        .o_wdata   (w_st_wdata)
    );

    always_comb begin
        dmem.mbe   = 4'b0000;
        dmem.wdata = 32'h0;
        if (w_go && ctrl_in.mem_write) begin
            dmem.mbe   = w_st_mbe;
            dmem.wdata = w_st_wdata;
        end else if (w_go && ctrl_in.mem_read) begin
            dmem.mbe   = MBE_ALL;
        end
    end

    // Bypass the response so MEM/WB captures load data on the response edge.
    assign mem_rdata_out = dmem.resp ? dmem.rdata : r_rdata_q;
    assign stall_count   = r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rdata_q     <= 32'h0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go && !dmem.resp)
                        r_state <= BUSY;
                    else if (w_go && dmem.resp && !advance)
                        r_state <= DONE;
                end
                BUSY: begin
                    if (dmem.resp)
                        r_state <= advance ? IDLE : DONE;
                end
                DONE: begin
                    if (advance)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (dmem.resp && w_go && ctrl_in.mem_read)
                r_rdata_q <= dmem.rdata;

            if (stall_req && !(&r_stall_count))
                r_stall_count <= r_stall_count + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && valid_in)
            assert (!(ctrl_in.mem_read && ctrl_in.mem_write))
            else $fatal(1, "mem_stage: control word has both mem_read and mem_write set");
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Scoreboard bench for mem_stage (directed load/store vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    rv32i_control_word ctrl_in;
    logic              valid_in;
    logic [31:0]       alu_out;
    logic [31:0]       rs2_out;
    logic              advance;
    logic [31:0]       mem_rdata_out;
    logic              stall_req;
    logic [CNT_W-1:0]  stall_count;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misaligned;
`endif

    mem_stage_if dmem();

    mem_stage #(.STALL_CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_in       (ctrl_in),
        .valid_in      (valid_in),
        .alu_out       (alu_out),
        .rs2_out       (rs2_out),
        .advance       (advance),
        .dmem          (dmem),
        .mem_rdata_out (mem_rdata_out),
        .stall_req     (stall_req),
        .stall_count   (stall_count)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic void check_word(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void push_req(input logic rd, input logic wr, input logic [31:0] addr,
                                     input logic [3:0] mbe, input logic [31:0] wdata);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.mbe = mbe; r.wdata = wdata;
        req_q.push_back(r);
    endfunction

    // Monitor: each new request is checked once; load data is checked on the response.
    logic seen = 1'b0;
    always @(negedge clk) begin
        req_t act, exp;
        if (!rst && (dmem.read || dmem.write)) begin
            if (!seen) begin
                act = {dmem.read, dmem.write, dmem.address, dmem.mbe, dmem.wdata};
                tests++;
                if (req_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_req: got %h expected none", act);
                end else begin
                    exp = req_q.pop_front();
                    if (act !== exp) begin
                        fails++;
                        $display("FAIL request: got rd=%b wr=%b addr=%h mbe=%b wdata=%h expected rd=%b wr=%b addr=%h mbe=%b wdata=%h",
                                 act.rd, act.wr, act.addr, act.mbe, act.wdata,
                                 exp.rd, exp.wr, exp.addr, exp.mbe, exp.wdata);
                    end
                end
            end
            seen = !dmem.resp;
            if (dmem.resp && dmem.read) begin
                tests++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_load: got %h expected none", mem_rdata_out);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    if (mem_rdata_out !== e) begin
                        fails++;
                        $display("FAIL load_data: got 0x%08h expected 0x%08h", mem_rdata_out, e);
                    end
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_op(input logic [2:0] f3, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] rs2);
        valid_in         = 1'b1;
        ctrl_in.opcode   = wr ? 7'b0100011 : 7'b0000011;
        ctrl_in.funct3   = f3;
        ctrl_in.mem_read = rd;
        ctrl_in.mem_write= wr;
        alu_out          = addr;
        rs2_out          = rs2;
    endtask

    task automatic bubble();
        valid_in = 1'b0;
        ctrl_in  = '0;
        alu_out  = 32'h0;
        rs2_out  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bubble();
        advance    = 1'b1;
        dmem.resp  = 1'b0;
        dmem.rdata = 32'h0;

        next_cycle();
        sample();
        check_bit("rst_read", dmem.read, 1'b0);
        check_bit("rst_stall", stall_req, 1'b0);
        next_cycle();
        rst = 1'b0;
        sample();
        check_word("rst_stall_count", 32'(stall_count), 32'd0);
        check_word("rst_rdata", mem_rdata_out, 32'h0);

        // sw with three-cycle miss
        next_cycle();
        set_op(3'b010, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
        advance = 1'b0;
        push_req(1'b0, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            sample();
            check_bit("sw_stall", stall_req, 1'b1);
            check_bit("sw_write", dmem.write, 1'b1);
            next_cycle();
        end
        dmem.resp = 1'b1;
        advance   = 1'b1;
        sample();
        check_bit("sw_resp_stall", stall_req, 1'b0);
        next_cycle();
        bubble();
        dmem.resp = 1'b0;
        sample();
        check_word("sw_stall_count", 32'(stall_count), 32'd3);
        check_bit("sw_write_drop", dmem.write, 1'b0);

        // zero-latency byte/half stores
        next_cycle();
        dmem.resp = 1'b1;
        set_op(3'b000, 1'b0, 1'b1, 32'h203, 32'h000000A5);
        push_req(1'b0, 1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5);
        sample();
        check_bit("sb_hit_stall", stall_req, 1'b0);
        next_cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h202, 32'h00001234);
        push_req(1'b0, 1'b1, 32'h200, 4'b1100, 32'h12341234);
        next_cycle();
        set_op(3'b000, 1'b0, 1'b1, 32'h201, 32'hFFFFFF3C);
        push_req(1'b0, 1'b1, 32'h200, 4'b0010, 32'h3C3C3C3C);
        next_cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h200, 32'hABCDBEEF);
        push_req(1'b0, 1'b1, 32'h200, 4'b0011, 32'hBEEFBEEF);
        next_cycle();

        // lw zero-latency hit
        set_op(3'b010, 1'b1, 1'b0, 32'h40, 32'h55555555);
        dmem.rdata = 32'hCAFEF00D;
        push_req(1'b1, 1'b0, 32'h40, 4'b1111, 32'h0);
        rd_q.push_back(32'hCAFEF00D);
        sample();
        check_bit("lw_hit_stall", stall_req, 1'b0);
        next_cycle();
        bubble();
        dmem.resp  = 1'b0;
        dmem.rdata = 32'h0;
        sample();
        check_word("lw_hit_hold", mem_rdata_out, 32'hCAFEF00D);
        check_bit("lw_hit_read_drop", dmem.read, 1'b0);

        // lw completes while pipeline held by another hazard -> DONE
        next_cycle();
        set_op(3'b010, 1'b1, 1'b0, 32'h44, 32'h0);
        advance = 1'b0;
        push_req(1'b1, 1'b0, 32'h44, 4'b1111, 32'h0);
        rd_q.push_back(32'h12345678);
        sample();
        check_bit("lw_miss_stall", stall_req, 1'b1);
        next_cycle();
        dmem.resp  = 1'b1;
        dmem.rdata = 32'h12345678;
        sample();
        check_bit("lw_resp_stall", stall_req, 1'b0);
        next_cycle();
        dmem.resp  = 1'b0;
        dmem.rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check_bit("done_read", dmem.read, 1'b0);
            check_bit("done_stall", stall_req, 1'b0);
            check_word("done_hold", mem_rdata_out, 32'h12345678);
            next_cycle();
        end
        advance = 1'b1;
        sample();
        check_bit("done_adv_read", dmem.read, 1'b0);
        next_cycle();
        set_op(3'b010, 1'b1, 1'b0, 32'h48, 32'h0);
        dmem.resp  = 1'b1;
        dmem.rdata = 32'h0BADCAFE;
        push_req(1'b1, 1'b0, 32'h48, 4'b1111, 32'h0);
        rd_q.push_back(32'h0BADCAFE);
        sample();
        check_bit("idle_again_read", dmem.read, 1'b1);
        next_cycle();
        bubble();
        dmem.resp  = 1'b0;
        dmem.rdata = 32'h0;
        sample();
        check_word("stall_count_sat", 32'(stall_count), 32'd3);

        // reset while BUSY
        next_cycle();
        set_op(3'b010, 1'b1, 1'b0, 32'h80, 32'h0);
        advance = 1'b0;
        push_req(1'b1, 1'b0, 32'h80, 4'b1111, 32'h0);
        sample();
        check_bit("busy_stall", stall_req, 1'b1);
        next_cycle();
        rst = 1'b1;
        sample();
        check_bit("rst_busy_read", dmem.read, 1'b0);
        check_bit("rst_busy_stall", stall_req, 1'b0);
        next_cycle();
        rst = 1'b0;
        bubble();
        advance = 1'b1;
        sample();
        check_word("rst_busy_count", 32'(stall_count), 32'd0);
        check_bit("rst_busy_read_after", dmem.read, 1'b0);
        next_cycle();
        set_op(3'b010, 1'b1, 1'b0, 32'h84, 32'h0);
        dmem.resp  = 1'b1;
        dmem.rdata = 32'h600DF00D;
        push_req(1'b1, 1'b0, 32'h84, 4'b1111, 32'h0);
        rd_q.push_back(32'h600DF00D);
        sample();
        check_bit("post_rst_read", dmem.read, 1'b1);
        next_cycle();
        bubble();
        dmem.resp  = 1'b0;
        dmem.rdata = 32'h0;

`ifdef MEM_MISALIGN_TRAP_EN
        next_cycle();
        set_op(3'b010, 1'b0, 1'b1, 32'h102, 32'h11112222);
        sample();
        check_bit("mis_flag", misaligned, 1'b1);
        check_bit("mis_write", dmem.write, 1'b0);
        check_bit("mis_stall", stall_req, 1'b0);
        next_cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h202, 32'h00005678);
        dmem.resp = 1'b1;
        push_req(1'b0, 1'b1, 32'h200, 4'b1100, 32'h56785678);
        sample();
        check_bit("aligned_flag", misaligned, 1'b0);
`else
        next_cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h203, 32'h00005678);
        dmem.resp = 1'b1;
        push_req(1'b0, 1'b1, 32'h200, 4'b1100, 32'h56785678);
        sample();
        check_bit("sh_odd_stall", stall_req, 1'b0);
`endif
        next_cycle();
        bubble();
        dmem.resp = 1'b0;
        next_cycle();
        next_cycle();
        check_word("req_q_drained", 32'(req_q.size()), 32'd0);
        check_word("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
